// File: rtl/rf_access_sequencer.sv
// Sequencer/arbiter sharing a single-ported-per-cycle register file
// between a two-operand read client and a write client.
module rf_access_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_WP    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RD_REQ,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR1,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR2,
    output logic                  RD_ACK,
    output logic [DATA_WIDTH-1:0] RD_DATA1,
    output logic [DATA_WIDTH-1:0] RD_DATA2,
    input  logic                  WR_REQ,
    input  logic [ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  WR_ACK,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
    output logic                  BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_HOLD,
        WR_ISSUE
    } state_e;

    state_e                state_q, state_d;
    logic                  last_rd_q, last_rd_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  wr_ack_q, wr_ack_d;
    logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
    logic [ADDR_WIDTH-1:0] addr_r1_q, addr_r1_d;
    logic [ADDR_WIDTH-1:0] addr_r2_q, addr_r2_d;
    logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;

    logic rd_elig, wr_elig;
    logic grant_rd, grant_wr;
    logic wr_blocked;

    // A client whose ACK is on the bus this cycle is still holding the
    // REQ of the finished transaction, so it sits out this arbitration.
    assign rd_elig  = RD_REQ && !rd_ack_q;
    assign wr_elig  = WR_REQ && !wr_ack_q;
    assign grant_rd = rd_elig && (!wr_elig || !last_rd_q);
    assign grant_wr = wr_elig && (!rd_elig || last_rd_q);

    always_comb begin
        state_d    = state_q;
        last_rd_d  = last_rd_q;
        rd_ack_d   = 1'b0;
        wr_ack_d   = 1'b0;
        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        addr_r1_d  = addr_r1_q;
        addr_r2_d  = addr_r2_q;
        addr_w_d   = addr_w_q;
        data_w_d   = data_w_q;
        unique case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    state_d   = RD_ISSUE;
                    last_rd_d = 1'b1;
                    addr_r1_d = RD_ADDR1;
                    addr_r2_d = RD_ADDR2;
                end else if (grant_wr) begin
                    state_d   = WR_ISSUE;
                    last_rd_d = 1'b0;
                    addr_w_d  = WR_ADDR;
                    data_w_d  = WR_DATA;
                end
            end
            RD_ISSUE: begin
                state_d = RD_HOLD;
            end
            RD_HOLD: begin
                rd_data1_d = RF_DATA_R1;
                rd_data2_d = RF_DATA_R2;
                rd_ack_d   = 1'b1;
                state_d    = IDLE;
            end
            WR_ISSUE: begin
                wr_ack_d = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            last_rd_q  <= 1'b1;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            addr_r1_q  <= '0;
            addr_r2_q  <= '0;
            addr_w_q   <= '0;
            data_w_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_rd_q  <= last_rd_d;
            rd_ack_q   <= rd_ack_d;
            wr_ack_q   <= wr_ack_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            addr_r1_q  <= addr_r1_d;
            addr_r2_q  <= addr_r2_d;
            addr_w_q   <= addr_w_d;
            data_w_q   <= data_w_d;
        end
    end

    // Strobes are gated by RST so an aborted cycle never touches the file.
    assign wr_blocked = ZERO_WP && (addr_w_q == '0);
    assign RF_READ    = !RST && ((state_q == RD_ISSUE) || (state_q == RD_HOLD));
    assign RF_WRITE   = !RST && (state_q == WR_ISSUE) && !wr_blocked;
    assign BUSY       = (state_q != IDLE);

    assign RD_ACK     = rd_ack_q;
    assign WR_ACK     = wr_ack_q;
    assign RD_DATA1   = rd_data1_q;
    assign RD_DATA2   = rd_data2_q;
    assign RF_ADDR_R1 = addr_r1_q;
    assign RF_ADDR_R2 = addr_r2_q;
    assign RF_ADDR_W  = addr_w_q;
    assign RF_DATA_W  = data_w_q;

    a_strobe_excl: assert property (@(posedge CLK) !(RF_READ && RF_WRITE));
    a_rd_ack_pulse: assert property (@(posedge CLK) disable iff (RST) RD_ACK |=> !RD_ACK);
    a_wr_ack_pulse: assert property (@(posedge CLK) disable iff (RST) WR_ACK |=> !WR_ACK);

endmodule

// File: tb/tb_rf_access_sequencer.sv
// Directed bench for rf_access_sequencer with a behavioural
// register file that captures on RF_READ and writes on RF_WRITE.
module tb_rf_access_sequencer;

    logic        CLK;
    logic        RST;
    logic        RD_REQ;
    logic [4:0]  RD_ADDR1, RD_ADDR2;
    logic        RD_ACK;
    logic [31:0] RD_DATA1, RD_DATA2;
    logic        WR_REQ;
    logic [4:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic        WR_ACK;
    logic        RF_READ, RF_WRITE;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [31:0] RF_DATA_W;
    logic [31:0] RF_DATA_R1, RF_DATA_R2;
    logic        BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    rf_access_sequencer #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .ZERO_WP(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RD_REQ(RD_REQ), .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2),
        .RD_ACK(RD_ACK), .RD_DATA1(RD_DATA1), .RD_DATA2(RD_DATA2),
        .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .WR_ACK(WR_ACK),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
        .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W),
        .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file model: capture on a read cycle, data valid while READ held
    logic [31:0] mem [32] = '{default: 32'h0};
    logic [31:0] cap1, cap2;
    always @(posedge CLK) begin
        if (RF_WRITE) mem[RF_ADDR_W] <= RF_DATA_W;
        if (RF_READ && !RF_WRITE) begin
            cap1 <= mem[RF_ADDR_R1];
            cap2 <= mem[RF_ADDR_R2];
        end
    end
    assign RF_DATA_R1 = (RF_READ && !RF_WRITE) ? cap1 : 32'hBAD0_BAD0;
    assign RF_DATA_R2 = (RF_READ && !RF_WRITE) ? cap2 : 32'hBAD0_BAD0;

    int rfw_cnt = 0;
    int ovl_cnt = 0;
    always @(negedge CLK) begin
        if (RF_WRITE) rfw_cnt++;
        if (RF_READ && RF_WRITE) ovl_cnt++;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2,
                           output int lat, output logic [31:0] d1,
                           output logic [31:0] d2);
        RD_ADDR1 = a1;
        RD_ADDR2 = a2;
        RD_REQ = 1'b1;
        lat = 0;
        d1 = '0;
        d2 = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (RD_ACK) begin
                lat = i;
                d1 = RD_DATA1;
                d2 = RD_DATA2;
                break;
            end
        end
        RD_REQ = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            output int lat);
        WR_ADDR = a;
        WR_DATA = d;
        WR_REQ = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (WR_ACK) begin
                lat = i;
                break;
            end
        end
        WR_REQ = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick();
        tick();
        n_cmp++; if (RD_ACK !== 1'b0) begin n_bad++; $display("FAIL rst_rd_ack got %b want 0", RD_ACK); end
        n_cmp++; if (WR_ACK !== 1'b0) begin n_bad++; $display("FAIL rst_wr_ack got %b want 0", WR_ACK); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", BUSY); end
        n_cmp++; if ({RD_DATA1, RD_DATA2} !== 64'h0) begin n_bad++; $display("FAIL rst_rd_data got %h %h want 0", RD_DATA1, RD_DATA2); end
        n_cmp++; if ({RF_READ, RF_WRITE} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes got %b want 00", {RF_READ, RF_WRITE}); end
        n_cmp++; if ({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W} !== 47'h0) begin n_bad++; $display("FAIL rst_rf_bus got %h want 0", {RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W}); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_single_read;
        int lat;
        int w0;
        logic [31:0] d1, d2;
        do_write(5'd5, 32'h0000_00AA, lat);
        do_write(5'd9, 32'h1234_5678, lat);
        w0 = rfw_cnt;
        do_read(5'd5, 5'd9, lat, d1, d2);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency got %0d want 3", lat); end
        n_cmp++; if (d1 !== 32'h0000_00AA) begin n_bad++; $display("FAIL rd_data1 got %h want 000000aa", d1); end
        n_cmp++; if (d2 !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data2 got %h want 12345678", d2); end
        n_cmp++; if (RD_ACK !== 1'b0) begin n_bad++; $display("FAIL rd_ack_width got %b want 0", RD_ACK); end
        n_cmp++; if (rfw_cnt - w0 !== 0) begin n_bad++; $display("FAIL rd_no_write got %0d want 0", rfw_cnt - w0); end
        tick();
        n_cmp++; if (RD_DATA1 !== 32'h0000_00AA) begin n_bad++; $display("FAIL rd_data_hold got %h want 000000aa", RD_DATA1); end
    endtask

    task automatic test_write_then_read;
        int lat;
        logic [31:0] d1, d2;
        do_write(5'd3, 32'hDEAD_BEEF, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL wr_latency got %0d want 2", lat); end
        n_cmp++; if (mem[3] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_commit got %h want deadbeef", mem[3]); end
        do_read(5'd3, 5'd5, lat, d1, d2);
        n_cmp++; if (d1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL raw_data1 got %h want deadbeef", d1); end
        n_cmp++; if (d2 !== 32'h0000_00AA) begin n_bad++; $display("FAIL raw_data2 got %h want 000000aa", d2); end
    endtask

    task automatic test_zero_wp;
        int lat;
        int w0;
        logic [31:0] d1, d2;
        w0 = rfw_cnt;
        do_write(5'd0, 32'hFFFF_FFFF, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL zwp_latency got %0d want 2", lat); end
        n_cmp++; if (rfw_cnt - w0 !== 0) begin n_bad++; $display("FAIL zwp_strobe got %0d cycles want 0", rfw_cnt - w0); end
        do_read(5'd0, 5'd0, lat, d1, d2);
        n_cmp++; if (d1 !== 32'h0) begin n_bad++; $display("FAIL zwp_r0 got %h want 0", d1); end
    endtask

    task automatic test_simultaneous;
        int wr_at, rd_at, k;
        logic [31:0] d;
        int at [4];
        logic isw [4];
        int exp_at [4];
        logic exp_w [4];
        exp_at = '{2, 5, 7, 10};
        exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
        at = '{default: 0};
        isw = '{default: 1'b0};
        RST = 1'b1;
        tick();
        RST = 1'b0;
        RD_ADDR1 = 5'd7;
        RD_ADDR2 = 5'd7;
        WR_ADDR = 5'd7;
        WR_DATA = 32'h55;
        RD_REQ = 1'b1;
        WR_REQ = 1'b1;
        wr_at = 0;
        rd_at = 0;
        d = '0;
        for (int i = 1; i <= 20 && rd_at == 0; i++) begin
            tick();
            if (WR_ACK && wr_at == 0) begin wr_at = i; WR_REQ = 1'b0; end
            if (RD_ACK) begin rd_at = i; d = RD_DATA1; RD_REQ = 1'b0; end
        end
        tick();
        n_cmp++; if (wr_at !== 2) begin n_bad++; $display("FAIL sim_wr_ack_at got %0d want 2", wr_at); end
        n_cmp++; if (rd_at !== 5) begin n_bad++; $display("FAIL sim_rd_ack_at got %0d want 5", rd_at); end
        n_cmp++; if (d !== 32'h55) begin n_bad++; $display("FAIL sim_rd_data got %h want 00000055", d); end
        WR_DATA = 32'h66;
        RD_REQ = 1'b1;
        WR_REQ = 1'b1;
        k = 0;
        for (int i = 1; i <= 30 && k < 4; i++) begin
            tick();
            if (WR_ACK) begin at[k] = i; isw[k] = 1'b1; k++; end
            if (RD_ACK && k < 4) begin
                at[k] = i;
                isw[k] = 1'b0;
                if (k == 1) d = RD_DATA1;
                k++;
            end
        end
        RD_REQ = 1'b0;
        WR_REQ = 1'b0;
        tick();
        n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL alt_ack_count got %0d want 4", k); end
        for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (at[j] !== exp_at[j] || isw[j] !== exp_w[j]) begin
                n_bad++;
                $display("FAIL alt_grant%0d got cyc %0d wr %b want cyc %0d wr %b", j, at[j], isw[j], exp_at[j], exp_w[j]);
            end
        end
        n_cmp++; if (d !== 32'h66) begin n_bad++; $display("FAIL alt_rd_data got %h want 00000066", d); end
    endtask

    task automatic test_reset_mid;
        int lat;
        WR_ADDR = 5'd4;
        WR_DATA = 32'h77;
        WR_REQ = 1'b1;
        tick();
        n_cmp++; if ({BUSY, RF_WRITE} !== 2'b11) begin n_bad++; $display("FAIL mid_in_wr got %b want 11", {BUSY, RF_WRITE}); end
        RST = 1'b1;
        WR_REQ = 1'b0;
        #1;
        n_cmp++; if (RF_WRITE !== 1'b0) begin n_bad++; $display("FAIL mid_gate got %b want 0", RF_WRITE); end
        tick();
        n_cmp++; if ({WR_ACK, RD_ACK, BUSY, RF_READ, RF_WRITE} !== 5'b0) begin n_bad++; $display("FAIL mid_ctrl got %b want 00000", {WR_ACK, RD_ACK, BUSY, RF_READ, RF_WRITE}); end
        n_cmp++; if ({RD_DATA1, RD_DATA2} !== 64'h0) begin n_bad++; $display("FAIL mid_rd_data got %h %h want 0", RD_DATA1, RD_DATA2); end
        n_cmp++; if ({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W} !== 47'h0) begin n_bad++; $display("FAIL mid_rf_bus got %h want 0", {RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W}); end
        n_cmp++; if (mem[4] !== 32'h0) begin n_bad++; $display("FAIL mid_r4 got %h want 0", mem[4]); end
        RST = 1'b0;
        tick();
        n_cmp++; if (WR_ACK !== 1'b0) begin n_bad++; $display("FAIL mid_no_ack got %b want 0", WR_ACK); end
        do_write(5'd4, 32'h77, lat);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mid_retry_lat got %0d want 2", lat); end
        n_cmp++; if (mem[4] !== 32'h77) begin n_bad++; $display("FAIL mid_retry_r4 got %h want 00000077", mem[4]); end
    endtask

    task automatic test_ack_rule;
        int k;
        int n;
        int at [3];
        at = '{default: 0};
        RD_ADDR1 = 5'd5;
        RD_ADDR2 = 5'd9;
        RD_REQ = 1'b1;
        k = 0;
        for (int i = 1; i <= 20 && k < 3; i++) begin
            tick();
            if (RD_ACK) begin at[k] = i; k++; end
        end
        RD_REQ = 1'b0;
        tick();
        n_cmp++; if (at[0] !== 3 || at[1] !== 7 || at[2] !== 11) begin n_bad++; $display("FAIL held_ack_cyc got %0d %0d %0d want 3 7 11", at[0], at[1], at[2]); end
        RD_REQ = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (RD_ACK) n++;
            if (i == 4) RD_REQ = 1'b0;
        end
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL window_acks got %0d want 1", n); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL window_idle got %b want 0", BUSY); end
        n_cmp++; if (ovl_cnt !== 0) begin n_bad++; $display("FAIL strobe_overlap got %0d want 0", ovl_cnt); end
    endtask

    initial begin
        RST = 1'b1;
        RD_REQ = 1'b0;
        WR_REQ = 1'b0;
        RD_ADDR1 = '0;
        RD_ADDR2 = '0;
        WR_ADDR = '0;
        WR_DATA = '0;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_zero_wp();
        test_simultaneous();
        test_reset_mid();
        test_ack_rule();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
